// File: rtl/vga_io_pkg.sv
// -----------------------------------------------------------------------------
// vga_io_pkg
//   Shared definitions for the VGA port-I/O front end:
//     - 16-bit I/O port addresses decoded by vga_io_ctrl
//     - CRTC register indices reachable through the 0x3D4/0x3D5 pair
//     - bus-handshake FSM state type and the 2-bit DAC component phase type
//     - 6-bit to 8-bit DAC component expansion helper
// -----------------------------------------------------------------------------
package vga_io_pkg;

   // I/O port addresses (full 16-bit decode)
   localparam logic [15:0] PORT_CRTC_IDX = 16'h03D4;
   localparam logic [15:0] PORT_CRTC_DAT = 16'h03D5;
   localparam logic [15:0] PORT_MODE     = 16'h03D8;
   localparam logic [15:0] PORT_STATUS   = 16'h03DA;
   localparam logic [15:0] PORT_DAC_RIDX = 16'h03C7;
   localparam logic [15:0] PORT_DAC_WIDX = 16'h03C8;
   localparam logic [15:0] PORT_DAC_DATA = 16'h03C9;

   // CRTC register indices
   localparam logic [4:0] CRTC_CUR_START = 5'h0A;
   localparam logic [4:0] CRTC_CUR_END   = 5'h0B;
   localparam logic [4:0] CRTC_CUR_HI    = 5'h0E;
   localparam logic [4:0] CRTC_CUR_LO    = 5'h0F;

   // Bus handshake states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_ACK     = 2'd2
   } state_t;

   // Position within an R,G,B triplet
   typedef logic [1:0] phase_t;

   // Widen a 6-bit DAC component to 8 bits by replicating its top bits, so
   // full scale 0x3F maps to 0xFF and zero stays zero.
   function automatic logic [7:0] expand6(input logic [5:0] v);
      return {v, v[5:4]};
   endfunction

endpackage

// File: rtl/vga_dac_seq.sv
// -----------------------------------------------------------------------------
// vga_dac_seq
//   DAC palette sequencer. Assembles R,G,B writes on the data port into one
//   32-bit palette word and splits palette reads back into three 6-bit
//   components. Write and read sequences are fully independent.
//
//   Ports:
//     clock, reset   system clock, asynchronous active-high reset
//     widx_we        load write index from wdata (port 0x3C8 written)
//     ridx_we        load read index from wdata (port 0x3C7 written)
//     data_we        one component written to the data port (0x3C9)
//     rd_step        one component consumed from the data port (0x3C9)
//     wdata          CPU OUT data
//     dac_rdata      palette word for dac_raddr, one-cycle read latency
//     widx           current write index (read back through 0x3C8)
//     rd_byte        component selected by the read phase, zero-extended
//     dac_we         one-cycle palette write strobe
//     dac_waddr      palette write address
//     dac_wdata      palette word 0x00RRGGBB
//     dac_raddr      palette read address (the registered read index)
// -----------------------------------------------------------------------------
module vga_dac_seq
   import vga_io_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        widx_we,
   input  logic        ridx_we,
   input  logic        data_we,
   input  logic        rd_step,
   input  logic [7:0]  wdata,
   input  logic [31:0] dac_rdata,
   output logic [7:0]  widx,
   output logic [7:0]  rd_byte,
   output logic        dac_we,
   output logic [7:0]  dac_waddr,
   output logic [31:0] dac_wdata,
   output logic [7:0]  dac_raddr
);

   logic [7:0]  widx_q,      widx_d;
   phase_t      wphase_q,    wphase_d;
   logic [5:0]  r_hold_q,    r_hold_d;
   logic [5:0]  g_hold_q,    g_hold_d;
   logic [7:0]  ridx_q,      ridx_d;
   phase_t      rphase_q,    rphase_d;
   logic        dac_we_q,    dac_we_d;
   logic [7:0]  dac_waddr_q, dac_waddr_d;
   logic [31:0] dac_wdata_q, dac_wdata_d;

   // Only the top six bits of each palette byte are visible to the CPU.
   logic unused_rdata_bits;
   assign unused_rdata_bits = ^{dac_rdata[31:24], dac_rdata[17:16],
                                dac_rdata[9:8], dac_rdata[1:0]};

   // ---------------- write sequence ----------------
   always_comb begin
      widx_d      = widx_q;
      wphase_d    = wphase_q;
      r_hold_d    = r_hold_q;
      g_hold_d    = g_hold_q;
      dac_we_d    = 1'b0;
      dac_waddr_d = dac_waddr_q;
      dac_wdata_d = dac_wdata_q;

      if (widx_we) begin
         // A new write index restarts the triplet; any held R/G is dropped.
         widx_d   = wdata;
         wphase_d = 2'd0;
         r_hold_d = '0;
         g_hold_d = '0;
      end else if (data_we) begin
         case (wphase_q)
            2'd0: begin
               r_hold_d = wdata[5:0];
               wphase_d = 2'd1;
            end
            2'd1: begin
               g_hold_d = wdata[5:0];
               wphase_d = 2'd2;
            end
            default: begin
               // Blue completes the triplet: commit the whole word at once.
               dac_we_d    = 1'b1;
               dac_waddr_d = widx_q;
               dac_wdata_d = {8'h00, expand6(r_hold_q), expand6(g_hold_q),
                              expand6(wdata[5:0])};
               widx_d      = widx_q + 8'd1;
               wphase_d    = 2'd0;
            end
         endcase
      end
   end

   // ---------------- read sequence ----------------
   always_comb begin
      ridx_d   = ridx_q;
      rphase_d = rphase_q;

      if (ridx_we) begin
         ridx_d   = wdata;
         rphase_d = 2'd0;
      end else if (rd_step) begin
         if (rphase_q >= 2'd2) begin
            ridx_d   = ridx_q + 8'd1;
            rphase_d = 2'd0;
         end else begin
            rphase_d = rphase_q + 2'd1;
         end
      end
   end

   always_comb begin
      case (rphase_q)
         2'd0:    rd_byte = {2'b00, dac_rdata[23:18]};
         2'd1:    rd_byte = {2'b00, dac_rdata[15:10]};
         default: rd_byte = {2'b00, dac_rdata[7:2]};
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         widx_q      <= '0;
         wphase_q    <= 2'd0;
         r_hold_q    <= '0;
         g_hold_q    <= '0;
         ridx_q      <= '0;
         rphase_q    <= 2'd0;
         dac_we_q    <= 1'b0;
         dac_waddr_q <= '0;
         dac_wdata_q <= '0;
      end else begin
         widx_q      <= widx_d;
         wphase_q    <= wphase_d;
         r_hold_q    <= r_hold_d;
         g_hold_q    <= g_hold_d;
         ridx_q      <= ridx_d;
         rphase_q    <= rphase_d;
         dac_we_q    <= dac_we_d;
         dac_waddr_q <= dac_waddr_d;
         dac_wdata_q <= dac_wdata_d;
      end
   end

   assign widx      = widx_q;
   assign dac_we    = dac_we_q;
   assign dac_waddr = dac_waddr_q;
   assign dac_wdata = dac_wdata_q;
   // The read index register drives the palette address directly, so a new
   // index is presented to the RAM the cycle after it is written.
   assign dac_raddr = ridx_q;

endmodule

// File: rtl/vga_io_ctrl.sv
// -----------------------------------------------------------------------------
// vga_io_ctrl
//   x86 port-I/O front end for the scanout engine. Decodes IN/OUT cycles for
//   the CRTC index/data pair, mode register, input status register and the
//   DAC palette ports, and drives cursor/shape/videomode to the scanout.
//
//   Ports:
//     clock, reset          system clock, asynchronous active-high reset
//     port_addr/wdata       I/O address and OUT data
//     port_we / port_re     one-cycle OUT / IN strobes (write wins if both)
//     port_rdata/port_ack   IN data held from ack to ack, one-cycle ack pulse
//     vs_in, blank_in       status inputs sampled on a 0x3DA read
//     cursor, cursor_shape_lo/hi, videomode   scanout configuration
//     dac_we/waddr/wdata    palette write port
//     dac_raddr/dac_rdata   palette read port (one-cycle RAM latency)
// -----------------------------------------------------------------------------
module vga_io_ctrl
   import vga_io_pkg::*;
#(
   parameter logic [5:0] CURSOR_LO_RST = 6'd14,
   parameter logic [4:0] CURSOR_HI_RST = 5'd15,
   parameter logic [1:0] MODE_RST      = 2'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] port_addr,
   input  logic [7:0]  port_wdata,
   input  logic        port_we,
   input  logic        port_re,
   output logic [7:0]  port_rdata,
   output logic        port_ack,
   input  logic        vs_in,
   input  logic        blank_in,
   output logic [10:0] cursor,
   output logic [5:0]  cursor_shape_lo,
   output logic [4:0]  cursor_shape_hi,
   output logic [1:0]  videomode,
   output logic        dac_we,
   output logic [7:0]  dac_waddr,
   output logic [31:0] dac_wdata,
   output logic [7:0]  dac_raddr,
   input  logic [31:0] dac_rdata
);

   state_t      state_q,    state_d;
   logic [4:0]  crtc_idx_q, crtc_idx_d;
   logic [10:0] cursor_q,   cursor_d;
   logic [5:0]  shape_lo_q, shape_lo_d;
   logic [4:0]  shape_hi_q, shape_hi_d;
   logic [1:0]  mode_q,     mode_d;
   logic [7:0]  rdata_q,    rdata_d;

   logic        dac_widx_we;
   logic        dac_ridx_we;
   logic        dac_data_we;
   logic        dac_rd_step;
   logic [7:0]  dac_widx;
   logic [7:0]  dac_rd_byte;
   logic [7:0]  crtc_rd;

   // CRTC data-port read value for the currently selected index.
   always_comb begin
      case (crtc_idx_q)
         CRTC_CUR_START: crtc_rd = {2'b00, shape_lo_q};
         CRTC_CUR_END:   crtc_rd = {3'b000, shape_hi_q};
         CRTC_CUR_HI:    crtc_rd = {5'b00000, cursor_q[10:8]};
         CRTC_CUR_LO:    crtc_rd = cursor_q[7:0];
         default:        crtc_rd = 8'h00;
      endcase
   end

   // Handshake FSM plus register decode. Strobes are only looked at in IDLE,
   // so anything arriving while a transaction is in flight is dropped.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path can
      // leave it unassigned, which would infer a latch.
      state_d     = state_q;
      crtc_idx_d  = crtc_idx_q;
      cursor_d    = cursor_q;
      shape_lo_d  = shape_lo_q;
      shape_hi_d  = shape_hi_q;
      mode_d      = mode_q;
      rdata_d     = rdata_q;
      dac_widx_we = 1'b0;
      dac_ridx_we = 1'b0;
      dac_data_we = 1'b0;
      dac_rd_step = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (port_we) begin
               // Write takes priority; a simultaneous read is discarded.
               state_d = ST_ACK;
               case (port_addr)
                  PORT_CRTC_IDX: crtc_idx_d = port_wdata[4:0];
                  PORT_CRTC_DAT: begin
                     case (crtc_idx_q)
                        CRTC_CUR_START: shape_lo_d     = port_wdata[5:0];
                        CRTC_CUR_END:   shape_hi_d     = port_wdata[4:0];
                        CRTC_CUR_HI:    cursor_d[10:8] = port_wdata[2:0];
                        CRTC_CUR_LO:    cursor_d[7:0]  = port_wdata;
                        default:        ;
                     endcase
                  end
                  PORT_MODE:     mode_d      = port_wdata[1:0];
                  PORT_DAC_RIDX: dac_ridx_we = 1'b1;
                  PORT_DAC_WIDX: dac_widx_we = 1'b1;
                  PORT_DAC_DATA: dac_data_we = 1'b1;
                  default:       ;
               endcase
            end else if (port_re) begin
               state_d = ST_ACK;
               case (port_addr)
                  PORT_CRTC_IDX: rdata_d = {3'b000, crtc_idx_q};
                  PORT_CRTC_DAT: rdata_d = crtc_rd;
                  PORT_MODE:     rdata_d = {6'b000000, mode_q};
                  PORT_STATUS:   rdata_d = {4'b0000, vs_in, 2'b00, blank_in};
                  PORT_DAC_WIDX: rdata_d = dac_widx;
                  // The palette RAM needs a cycle to present the word.
                  PORT_DAC_DATA: state_d = ST_RD_WAIT;
                  default:       rdata_d = 8'hFF;
               endcase
            end
         end
         ST_RD_WAIT: begin
            rdata_d     = dac_rd_byte;
            dac_rd_step = 1'b1;
            state_d     = ST_ACK;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         crtc_idx_q <= '0;
         cursor_q   <= '0;
         shape_lo_q <= CURSOR_LO_RST;
         shape_hi_q <= CURSOR_HI_RST;
         mode_q     <= MODE_RST;
         rdata_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // computed in this cycle, independent of statement order.
         state_q    <= state_d;
         crtc_idx_q <= crtc_idx_d;
         cursor_q   <= cursor_d;
         shape_lo_q <= shape_lo_d;
         shape_hi_q <= shape_hi_d;
         mode_q     <= mode_d;
         rdata_q    <= rdata_d;
      end
   end

   vga_dac_seq u_dac_seq (
      .clock     (clock),
      .reset     (reset),
      .widx_we   (dac_widx_we),
      .ridx_we   (dac_ridx_we),
      .data_we   (dac_data_we),
      .rd_step   (dac_rd_step),
      .wdata     (port_wdata),
      .dac_rdata (dac_rdata),
      .widx      (dac_widx),
      .rd_byte   (dac_rd_byte),
      .dac_we    (dac_we),
      .dac_waddr (dac_waddr),
      .dac_wdata (dac_wdata),
      .dac_raddr (dac_raddr)
   );

   // ACK is entered for exactly one cycle per accepted transaction.
   assign port_ack        = (state_q == ST_ACK);
   assign port_rdata      = rdata_q;
   assign cursor          = cursor_q;
   assign cursor_shape_lo = shape_lo_q;
   assign cursor_shape_hi = shape_hi_q;
   assign videomode       = mode_q;

endmodule

// File: tb/tb_vga_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_io_ctrl
//   Directed bench for vga_io_ctrl with a behavioural palette RAM
//   (one-cycle synchronous read) and hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_vga_io_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] port_addr = '0;
   logic [7:0]  port_wdata = '0;
   logic        port_we = 1'b0;
   logic        port_re = 1'b0;
   logic [7:0]  port_rdata;
   logic        port_ack;
   logic        vs_in = 1'b0;
   logic        blank_in = 1'b0;
   logic [10:0] cursor;
   logic [5:0]  cursor_shape_lo;
   logic [4:0]  cursor_shape_hi;
   logic [1:0]  videomode;
   logic        dac_we;
   logic [7:0]  dac_waddr;
   logic [31:0] dac_wdata;
   logic [7:0]  dac_raddr;
   logic [31:0] dac_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] pal [256];
   int          we_count = 0;
   logic [7:0]  last_waddr = '0;
   logic [31:0] last_wdata = '0;

   vga_io_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .port_addr       (port_addr),
      .port_wdata      (port_wdata),
      .port_we         (port_we),
      .port_re         (port_re),
      .port_rdata      (port_rdata),
      .port_ack        (port_ack),
      .vs_in           (vs_in),
      .blank_in        (blank_in),
      .cursor          (cursor),
      .cursor_shape_lo (cursor_shape_lo),
      .cursor_shape_hi (cursor_shape_hi),
      .videomode       (videomode),
      .dac_we          (dac_we),
      .dac_waddr       (dac_waddr),
      .dac_wdata       (dac_wdata),
      .dac_raddr       (dac_raddr),
      .dac_rdata       (dac_rdata)
   );

   always #5 clock = ~clock;

   // Palette RAM model: one-cycle synchronous read.
   always @(posedge clock) dac_rdata <= pal[dac_raddr];

   // Palette write monitor, sampled away from the active edge.
   always @(negedge clock) begin
      if (dac_we) begin
         we_count   = we_count + 1;
         last_waddr = dac_waddr;
         last_wdata = dac_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // OUT cycle; called at a negedge, returns at a negedge with the FSM idle.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      port_addr  = a;
      port_wdata = d;
      port_we    = 1'b1;
      @(negedge clock);
      port_we = 1'b0;
      check($sformatf("wr_ack_%0h", a), 32'(port_ack), 1);
      @(negedge clock);
   endtask

   // IN cycle with expected data and ack latency in cycles after port_re.
   task automatic bus_read(input string tag, input logic [15:0] a,
                           input logic [7:0] exp_d, input int exp_lat);
      int cycles;
      port_addr = a;
      port_re   = 1'b1;
      @(negedge clock);
      port_re = 1'b0;
      cycles  = 1;
      while (!port_ack && cycles < 6) begin
         @(negedge clock);
         cycles++;
      end
      check({tag, "_lat"}, 32'(cycles), 32'(exp_lat));
      check(tag, 32'(port_rdata), 32'(exp_d));
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic ack_seen;

      for (int i = 0; i < 256; i++) pal[i] = {8'h00, 8'(i), 8'(~i), 8'(i)};
      pal[5] = 32'h00FC8004;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // ---- reset state ----
      check("rst_cursor", 32'(cursor), 0);
      check("rst_shape_lo", 32'(cursor_shape_lo), 'h0E);
      check("rst_shape_hi", 32'(cursor_shape_hi), 'h0F);
      check("rst_mode", 32'(videomode), 0);
      check("rst_ack", 32'(port_ack), 0);
      check("rst_rdata", 32'(port_rdata), 0);
      check("rst_dac_we", 32'(dac_we), 0);
      check("rst_raddr", 32'(dac_raddr), 0);
      bus_read("crtc_idx_rst", 16'h03D4, 8'h00, 1);
      bus_write(16'h03D4, 8'h0A);
      bus_read("shape_lo_rd", 16'h03D5, 8'h0E, 1);
      bus_write(16'h03D4, 8'h0B);
      bus_read("shape_hi_rd", 16'h03D5, 8'h0F, 1);
      bus_read("crtc_idx_rd", 16'h03D4, 8'h0B, 1);
      check("no_dac_we", 32'(we_count), 0);

      // ---- cursor position ----
      bus_write(16'h03D4, 8'h0E);
      bus_write(16'h03D5, 8'h07);
      bus_write(16'h03D4, 8'h0F);
      bus_write(16'h03D5, 8'hCF);
      check("cursor", 32'(cursor), 'h7CF);
      bus_read("cursor_lo_rd", 16'h03D5, 8'hCF, 1);
      bus_write(16'h03D4, 8'h0E);
      bus_read("cursor_hi_rd", 16'h03D5, 8'h07, 1);
      bus_write(16'h03D4, 8'h11);
      bus_read("crtc_other_rd", 16'h03D5, 8'h00, 1);

      // ---- mode, status, unmapped ----
      bus_read("mode_rd", 16'h03D8, 8'h00, 1);
      vs_in = 1'b1; blank_in = 1'b0;
      bus_read("status_vs", 16'h03DA, 8'h08, 1);
      vs_in = 1'b0; blank_in = 1'b1;
      bus_read("status_blank", 16'h03DA, 8'h01, 1);
      bus_read("unmapped_rd", 16'h1234, 8'hFF, 1);

      // ---- DAC write triplet with index wrap ----
      base = we_count;
      bus_write(16'h03C8, 8'hFF);
      bus_write(16'h03C9, 8'h3F);
      bus_write(16'h03C9, 8'h00);
      bus_write(16'h03C9, 8'h15);
      check("dac_we_count", 32'(we_count - base), 1);
      check("dac_waddr", 32'(last_waddr), 'hFF);
      check("dac_wdata", last_wdata, 'h00FF0055);
      bus_read("widx_wrap", 16'h03C8, 8'h00, 1);

      // ---- DAC read triplet ----
      bus_write(16'h03C7, 8'h05);
      bus_read("dac_rd_r", 16'h03C9, 8'h3F, 2);
      bus_read("dac_rd_g", 16'h03C9, 8'h20, 2);
      bus_read("dac_rd_b", 16'h03C9, 8'h01, 2);
      check("raddr_inc", 32'(dac_raddr), 'h06);

      // ---- half triplet discarded by index rewrite ----
      base = we_count;
      bus_write(16'h03C8, 8'h10);
      bus_write(16'h03C9, 8'h01);
      bus_write(16'h03C9, 8'h01);
      bus_write(16'h03C8, 8'h20);
      bus_write(16'h03C9, 8'h01);
      bus_write(16'h03C9, 8'h02);
      bus_write(16'h03C9, 8'h03);
      check("discard_we_count", 32'(we_count - base), 1);
      check("discard_waddr", 32'(last_waddr), 'h20);
      check("discard_wdata", last_wdata, 'h0004080C);
      bus_read("widx_after", 16'h03C8, 8'h21, 1);

      // ---- simultaneous write and read: write wins, single ack ----
      port_addr  = 16'h03D8;
      port_wdata = 8'h02;
      port_we    = 1'b1;
      port_re    = 1'b1;
      @(negedge clock);
      port_we = 1'b0;
      port_re = 1'b0;
      check("both_ack", 32'(port_ack), 1);
      check("both_mode", 32'(videomode), 2);
      @(negedge clock);
      check("both_ack_gone", 32'(port_ack), 0);
      @(negedge clock);
      check("both_no_second_ack", 32'(port_ack), 0);
      bus_read("mode_rd2", 16'h03D8, 8'h02, 1);

      // ---- reset during RD_WAIT ----
      bus_write(16'h03C7, 8'h05);
      port_addr = 16'h03C9;
      port_re   = 1'b1;
      @(negedge clock);
      port_re  = 1'b0;
      reset    = 1'b1;
      ack_seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (port_ack) ack_seen = 1'b1;
         @(negedge clock);
         if (i == 1) reset = 1'b0;
      end
      check("rst_mid_no_ack", 32'(ack_seen), 0);
      check("rst_mid_cursor", 32'(cursor), 0);
      check("rst_mid_shape_lo", 32'(cursor_shape_lo), 'h0E);
      check("rst_mid_shape_hi", 32'(cursor_shape_hi), 'h0F);
      check("rst_mid_mode", 32'(videomode), 0);
      check("rst_mid_rdata", 32'(port_rdata), 0);
      check("rst_mid_raddr", 32'(dac_raddr), 0);
      check("rst_mid_waddr", 32'(dac_waddr), 0);
      check("rst_mid_wdata", dac_wdata, 0);
      check("rst_mid_dac_we", 32'(dac_we), 0);
      bus_read("widx_after_rst", 16'h03C8, 8'h00, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_io_ctrl.md
Name: vga_io_ctrl

Overview:
- x86 port-I/O front end that configures the text/graphics scanout engine.
- Decodes CPU IN/OUT cycles for the CRTC index/data pair (cursor position, cursor shape), the DAC palette index/data ports (R,G,B triplet sequencing with index auto-increment), the mode register and the input status register.
- Drives the cursor, cursor_shape and videomode inputs of the scanout engine.
- Writes and reads the 256x32 palette RAM that feeds its DAC lookup.

Parameters:
- CURSOR_LO_RST, 6'd14, reset value of cursor start row.
- CURSOR_HI_RST, 5'd15, reset value of cursor end row.
- MODE_RST, 2'd0, reset videomode (0 = 80x25 text).

Ports:
- clock  in  1  system clock (same domain as scanout)
- reset  in  1  asynchronous, active-high
- port_addr  in  16  I/O port address
- port_wdata  in  8  OUT data
- port_we  in  1  one-cycle OUT strobe
- port_re  in  1  one-cycle IN strobe
- port_rdata  out  8  IN data, valid while port_ack=1
- port_ack  out  1  one-cycle completion pulse
- vs_in  in  1  vertical sync from scanout
- blank_in  in  1  1 = outside visible window
- cursor  out  11  cursor cell index 0..2047
- cursor_shape_lo  out  6  cursor start row (bit5 = cursor off)
- cursor_shape_hi  out  5  cursor end row
- videomode  out  2  0 = text, 2 = 320x200x256
- dac_we  out  1  palette write strobe (one cycle)
- dac_waddr  out  8  palette write address
- dac_wdata  out  32  palette word 0x00RRGGBB
- dac_raddr  out  8  palette read address (registered)
- dac_rdata  in  32  palette word, 1-cycle synchronous read latency

Behaviour:
- Reset (async) values:
  - cursor=0, shape_lo=CURSOR_LO_RST, shape_hi=CURSOR_HI_RST, videomode=MODE_RST.
  - CRTC index=0; DAC write index, read index, write phase and read phase all 0.
  - dac_we=0, dac_waddr=0, dac_wdata=0, dac_raddr=0.
  - port_ack=0, port_rdata=0; FSM in IDLE.
  - Reset mid-transaction aborts it: no ack, partially assembled triplet discarded.
- FSM states: IDLE, RD_WAIT, ACK. Strobes are accepted only in IDLE; strobes arriving in RD_WAIT or ACK are ignored.
- Write in IDLE: register update takes effect next cycle; port_ack pulses next cycle; go to ACK, then IDLE.
- Read in IDLE:
  - 0x3C9 goes to RD_WAIT for one cycle so dac_rdata is valid, then ACK.
  - All other reads go directly to ACK.
  - port_rdata is registered and held until the next ack.
- port_we and port_re asserted together: the write wins and the read is dropped.
- Port map (full 16-bit decode):
  - 0x3D4 W/R: CRTC index [4:0].
  - 0x3D5 W/R, by CRTC index:
    - 0x0A: shape_lo <= wdata[5:0].
    - 0x0B: shape_hi <= wdata[4:0].
    - 0x0E: cursor[10:8] <= wdata[2:0].
    - 0x0F: cursor[7:0] <= wdata.
    - Other indices: writes ignored, reads return 0x00.
    - Reads return the stored value, zero-extended.
  - 0x3D8 W/R: videomode <= wdata[1:0]; reads return {6'b0, videomode}. Values 1 and 3 are stored as-is.
  - 0x3DA R: {4'b0, vs_in, 2'b0, blank_in}, sampled in the accepting cycle.
  - 0x3C7 W: read index <= wdata, read phase <= 0, dac_raddr <= wdata.
  - 0x3C8 W: write index <= wdata, write phase <= 0. 0x3C8 R: returns write index.
  - 0x3C9 W, by write phase:
    - Phases 0 and 1 latch the 6-bit R and G values into holding registers.
    - Phase 2 sets dac_we=1 for one cycle with dac_waddr = write index and dac_wdata = {8'h00, Rx, Gx, Bx}, where each component expands 6 to 8 bits as {v[5:0], v[5:4]}.
    - After phase 2: write index +1 (255 wraps to 0), phase returns to 0.
  - 0x3C9 R, by read phase:
    - Returns {2'b0, dac_rdata[23:18]}, then [15:10], then [7:2].
    - After phase 2: read index +1 (wraps), dac_raddr follows, phase returns to 0.
  - Unmapped ports: writes ignored, reads return 0xFF; port_ack is still generated.
- Writing 0x3C8 during a half-finished triplet discards the held components.
- The read and write DAC sequences are fully independent.

Decomposition:
- Package vga_io_pkg holds:
  - port address constants (PORT_CRTC_IDX, PORT_CRTC_DAT, PORT_MODE, PORT_STATUS, PORT_DAC_RIDX, PORT_DAC_WIDX, PORT_DAC_DATA);
  - CRTC index constants (CRTC_CUR_START=0x0A, CRTC_CUR_END=0x0B, CRTC_CUR_HI=0x0E, CRTC_CUR_LO=0x0F);
  - the FSM state enum and the 2-bit phase type.
- One sub-module, vga_dac_seq, owns the write/read indices, phases, triplet holding registers, 6-to-8-bit expansion, dac_we/dac_waddr/dac_wdata/dac_raddr and component selection for reads.

Test Plan:
- Reset, then read 0x3D5 at index 0x0A and 0x0B -> 0x0E and 0x0F; cursor=0; videomode=0; no dac_we.
- OUT 0x3D4,0x0E; OUT 0x3D5,0x07; OUT 0x3D4,0x0F; OUT 0x3D5,0xCF -> cursor=11'h7CF; each OUT acked exactly one cycle later.
- OUT 0x3C8,0xFF; OUT 0x3C9 with 0x3F, 0x00, 0x15 -> single dac_we with addr=0xFF, data=0x00FF0055; then IN 0x3C8 -> 0x00 (wrapped).
- Palette model holds entry 5 = 0x00FC8004; OUT 0x3C7,0x05; three IN 0x3C9 -> 0x3F, 0x20, 0x01, each acked 2 cycles after port_re; dac_raddr then = 0x06.
- OUT 0x3C8,0x10; OUT 0x3C9,0x01 twice; OUT 0x3C8,0x20; three OUT 0x3C9 -> exactly one dac_we, at addr 0x20.
- Same-cycle port_we (0x3D8, data 0x02) with port_re -> videomode=2, one ack; assert reset mid-RD_WAIT -> port_ack never pulses and all outputs take their reset values.
